// File: rtl/gbe_tx_seg_packer.sv
// rtl/gbe_tx_seg_packer.sv - segment compactor and frame-atomic packet FIFO for the GbE TX path
module gbe_tx_seg_packer #(
   parameter int N_SEG       = 4,
   parameter int SEG_BYTES   = 32,
   parameter int DEPTH       = 16,
   parameter int AFULL_LEVEL = 12
) (
   input  logic                         user_clk,
   input  logic                         axis_reset_n,
   input  logic [N_SEG*SEG_BYTES*8-1:0] gbe_tx_data,
   input  logic [N_SEG-1:0]             gbe_tx_valid,
   input  logic [N_SEG*SEG_BYTES-1:0]   gbe_tx_byte_enable,
   input  logic                         gbe_tx_end_of_frame,
   output logic                         gbe_tx_afull,
   output logic                         gbe_tx_overflow,
   output logic [N_SEG*SEG_BYTES*8-1:0] m_tdata,
   output logic [N_SEG*SEG_BYTES-1:0]   m_tkeep,
   output logic                         m_tlast,
   output logic                         m_tvalid,
   input  logic                         m_tready,
   output logic [31:0]                  frame_count,
   output logic [31:0]                  drop_count
);
   localparam int SB = SEG_BYTES*8;
   localparam int W  = N_SEG*SB;
   localparam int KB = N_SEG*SEG_BYTES;
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int LW = $clog2(2*N_SEG);
   localparam int SW = $clog2(N_SEG);
   localparam int EW = W + KB + 1;

   logic [SB-1:0]        acc_q [N_SEG];
   logic [LW-1:0]        acc_cnt_q;
   logic [PW-1:0]        wr_ptr_q, commit_ptr_q, rd_ptr_q;
   logic [PW-1:0]        wr_ptr_d, commit_ptr_d, rd_ptr_d;
   logic                 drop_q, afull_q, ovf_q;
   logic [31:0]          frame_cnt_q, drop_cnt_q;
   logic [EW-1:0]        mem_q [DEPTH];

   logic [SB-1:0]        lst_seg [2*N_SEG];
   logic [SEG_BYTES-1:0] lst_keep [2*N_SEG];
   logic [SB-1:0]        new_acc [N_SEG];
   logic [SEG_BYTES-1:0] be_last;
   logic [LW-1:0]        total, left, base, last_pos, idx;
   logic                 eof, full, part, ovf, accept;
   logic [1:0]           n_wr;
   logic [PW-1:0]        free_cnt;
   logic [W-1:0]         data_a, data_b;
   logic [KB-1:0]        keep_a, keep_b;
   logic [EW-1:0]        entry0, entry1, rd_entry;

   // Held segments first, then this cycle's valid segments in ascending order.
   always_comb begin
      eof      = gbe_tx_end_of_frame;
      for (int k = 0; k < 2*N_SEG; k++) begin
         lst_seg[LW'(k)]  = '0;
         lst_keep[LW'(k)] = '1;
      end
      for (int k = 0; k < N_SEG; k++)
         if (LW'(k) < acc_cnt_q) lst_seg[LW'(k)] = acc_q[SW'(k)];
      total    = acc_cnt_q;
      last_pos = '0;
      be_last  = '1;
      for (int i = 0; i < N_SEG; i++) begin
         if (gbe_tx_valid[i]) begin
            lst_seg[total] = gbe_tx_data[i*SB +: SB];
            last_pos       = total;
            be_last        = gbe_tx_byte_enable[i*SEG_BYTES +: SEG_BYTES];
            total          = total + 1'b1;
         end
      end
      if (eof && gbe_tx_valid != '0) lst_keep[last_pos] = be_last;

      full = total >= LW'(N_SEG);
      left = full ? total - LW'(N_SEG) : total;
      base = full ? LW'(N_SEG) : '0;
      part = eof && left != '0;
      n_wr = {1'b0, full} + {1'b0, part};

      data_a = '0;
      keep_a = '0;
      data_b = '0;
      keep_b = '0;
      idx    = '0;
      for (int j = 0; j < N_SEG; j++) begin
         data_a[j*SB +: SB]               = lst_seg[LW'(j)];
         keep_a[j*SEG_BYTES +: SEG_BYTES] = lst_keep[LW'(j)];
         idx                              = base + LW'(j);
         new_acc[SW'(j)]                  = lst_seg[idx];
         if (LW'(j) < left) begin
            data_b[j*SB +: SB]               = lst_seg[idx];
            keep_b[j*SEG_BYTES +: SEG_BYTES] = lst_keep[idx];
         end
      end

      // Free space is judged against rd_ptr before this cycle's read.
      free_cnt     = PW'(DEPTH) - (wr_ptr_q - rd_ptr_q);
      ovf          = !drop_q && (PW'(n_wr) > free_cnt);
      accept       = !drop_q && !ovf;
      wr_ptr_d     = accept ? wr_ptr_q + PW'(n_wr) : (ovf ? commit_ptr_q : wr_ptr_q);
      commit_ptr_d = (accept && eof && total != '0) ? wr_ptr_d : commit_ptr_q;
      rd_ptr_d     = rd_ptr_q + PW'(m_tvalid && m_tready);
      entry0       = full ? {eof && !part, keep_a, data_a} : {eof, keep_b, data_b};
      entry1       = {1'b1, keep_b, data_b};
   end

   always_ff @(posedge user_clk or negedge axis_reset_n) begin
      if (!axis_reset_n) begin
         for (int k = 0; k < N_SEG; k++) acc_q[SW'(k)] <= '0;
         acc_cnt_q    <= '0;
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         rd_ptr_q     <= '0;
         drop_q       <= 1'b0;
         afull_q      <= 1'b0;
         ovf_q        <= 1'b0;
         frame_cnt_q  <= '0;
         drop_cnt_q   <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         afull_q      <= (wr_ptr_d - rd_ptr_d) >= PW'(AFULL_LEVEL);
         ovf_q        <= ovf;
         if (drop_q) begin
            acc_cnt_q <= '0;
            if (eof) drop_q <= 1'b0;
         end else if (ovf) begin
            acc_cnt_q  <= '0;
            drop_q     <= !eof;
            drop_cnt_q <= drop_cnt_q + 1'b1;
         end else if (eof) begin
            acc_cnt_q <= '0;
            if (total != '0) frame_cnt_q <= frame_cnt_q + 1'b1;
         end else begin
            acc_cnt_q <= left;
            for (int k = 0; k < N_SEG; k++) acc_q[SW'(k)] <= new_acc[SW'(k)];
         end
      end
   end

   always_ff @(posedge user_clk) begin
      if (accept && n_wr != 2'd0) mem_q[wr_ptr_q[AW-1:0]] <= entry0;
      if (accept && n_wr == 2'd2) mem_q[wr_ptr_q[AW-1:0] + 1'b1] <= entry1;
   end

   assign m_tvalid                     = rd_ptr_q != commit_ptr_q;
   assign rd_entry                     = mem_q[rd_ptr_q[AW-1:0]];
   assign {m_tlast, m_tkeep, m_tdata}  = m_tvalid ? rd_entry : '0;
   assign gbe_tx_afull                 = afull_q;
   assign gbe_tx_overflow              = ovf_q;
   assign frame_count                  = frame_cnt_q;
   assign drop_count                   = drop_cnt_q;
endmodule

// File: tb/tb_gbe_tx_seg_packer.sv
// tb/tb_gbe_tx_seg_packer.sv - directed and random checks of gbe_tx_seg_packer against a frame-level model
module tb_gbe_tx_seg_packer;
   localparam int NS = 4, SBY = 32, DEP = 16, AFL = 12;
   localparam int SB = SBY*8, W = NS*SB, KB = NS*SBY;
   typedef struct { logic [W-1:0] d; logic [KB-1:0] k; logic l; } beat_t;

   logic          user_clk = 1'b0;
   logic          axis_reset_n;
   logic [W-1:0]  gbe_tx_data;
   logic [NS-1:0] gbe_tx_valid;
   logic [KB-1:0] gbe_tx_byte_enable;
   logic          gbe_tx_end_of_frame;
   logic          gbe_tx_afull, gbe_tx_overflow;
   logic [W-1:0]  m_tdata;
   logic [KB-1:0] m_tkeep;
   logic          m_tlast, m_tvalid, m_tready;
   logic [31:0]   frame_count, drop_count;

   gbe_tx_seg_packer #(.N_SEG(NS), .SEG_BYTES(SBY), .DEPTH(DEP), .AFULL_LEVEL(AFL)) dut (
      .user_clk(user_clk), .axis_reset_n(axis_reset_n), .gbe_tx_data(gbe_tx_data),
      .gbe_tx_valid(gbe_tx_valid), .gbe_tx_byte_enable(gbe_tx_byte_enable),
      .gbe_tx_end_of_frame(gbe_tx_end_of_frame), .gbe_tx_afull(gbe_tx_afull),
      .gbe_tx_overflow(gbe_tx_overflow), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
      .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .frame_count(frame_count), .drop_count(drop_count));

   always #5 user_clk = ~user_clk;

   int            n_assert = 0, n_fail = 0;
   beat_t         exp_q[$], got_q[$];
   logic [SB-1:0] fseg[$];
   logic [SBY-1:0] fkeep[$];
   bit            dropping = 0, ovf_exp = 0;
   int            fc = 0, dc = 0;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] rnd_data();
      logic [W-1:0] r;
      for (int i = 0; i < W/32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [KB-1:0] rnd_be();
      logic [KB-1:0] r;
      for (int s = 0; s < NS; s++) r[s*SBY +: SBY] = 32'hFFFF_FFFF >> (SBY - $urandom_range(1, SBY));
      return r;
   endfunction

   task automatic model_clear();
      exp_q.delete(); fseg.delete(); fkeep.delete();
      dropping = 0; ovf_exp = 0; fc = 0; dc = 0;
   endtask

   // Frame-level model: segments of the open frame are collected, then cut into beats at EOF.
   task automatic step(input logic [NS-1:0] v, input logic eof, input logic [KB-1:0] be, input logic [W-1:0] d);
      int occ, wa, hi, nb;
      beat_t b;
      gbe_tx_valid = v; gbe_tx_end_of_frame = eof; gbe_tx_byte_enable = be; gbe_tx_data = d;
      @(negedge user_clk);
      chk("tvalid", W'(m_tvalid), W'(exp_q.size() != 0));
      chk("afull", W'(gbe_tx_afull), W'((exp_q.size() + fseg.size()/NS) >= AFL));
      chk("overflow", W'(gbe_tx_overflow), W'(ovf_exp));
      chk("frame_count", W'(frame_count), W'(unsigned'(fc)));
      chk("drop_count", W'(drop_count), W'(unsigned'(dc)));
      occ = exp_q.size();
      if (m_tvalid && m_tready && exp_q.size() != 0) begin
         b = exp_q.pop_front();
         chk("tdata", m_tdata, b.d);
         chk("tkeep", W'(m_tkeep), W'(b.k));
         chk("tlast", W'(m_tlast), W'(b.l));
         got_q.push_back('{m_tdata, m_tkeep, m_tlast});
      end
      ovf_exp = 0;
      if (dropping) begin
         if (eof) dropping = 0;
      end else begin
         hi = -1;
         for (int i = 0; i < NS; i++) if (v[i]) begin
            fseg.push_back(d[i*SB +: SB]); fkeep.push_back('1); hi = i;
         end
         if (eof && hi >= 0) fkeep[fseg.size()-1] = be[hi*SBY +: SBY];
         wa = eof ? (fseg.size() + NS - 1) / NS : fseg.size() / NS;
         if (wa > DEP - occ) begin
            ovf_exp = 1; dc++; dropping = !eof;
            fseg.delete(); fkeep.delete();
         end else if (eof && fseg.size() != 0) begin
            nb = (fseg.size() + NS - 1) / NS;
            for (int bi = 0; bi < nb; bi++) begin
               b.d = '0; b.k = '0; b.l = (bi == nb - 1);
               for (int j = 0; j < NS; j++) if (bi*NS + j < fseg.size()) begin
                  b.d[j*SB +: SB]   = fseg[bi*NS + j];
                  b.k[j*SBY +: SBY] = fkeep[bi*NS + j];
               end
               exp_q.push_back(b);
            end
            fc++; fseg.delete(); fkeep.delete();
         end
      end
      @(posedge user_clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step('0, 1'b0, '0, '0);
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_tvalid"}, W'(m_tvalid), '0);
      chk({tag, "_afull"}, W'(gbe_tx_afull), '0);
      chk({tag, "_overflow"}, W'(gbe_tx_overflow), '0);
      chk({tag, "_frames"}, W'(frame_count), '0);
      chk({tag, "_drops"}, W'(drop_count), '0);
      chk({tag, "_tdata"}, m_tdata, '0);
      chk({tag, "_tkeep_tlast"}, W'({m_tkeep, m_tlast}), '0);
   endtask

   logic [W-1:0] d1, d2, d3;
   int pulses, pulse_at;

   initial begin
      axis_reset_n = 1'b0; m_tready = 1'b0;
      gbe_tx_valid = '0; gbe_tx_end_of_frame = 1'b0; gbe_tx_byte_enable = '0; gbe_tx_data = '0;
      #12;
      reset_checks("reset");
      @(negedge user_clk); axis_reset_n = 1'b1;
      @(posedge user_clk); #1;

      // three full beats, last with EOF
      m_tready = 1'b1; got_q.delete();
      step('1, 1'b0, '1, rnd_data());
      step('1, 1'b0, '1, rnd_data());
      step('1, 1'b1, '1, rnd_data());
      chk("t1_first_valid", W'(m_tvalid), W'(1));
      idle(5);
      chk("t1_beats", W'(got_q.size()), W'(3));
      chk("t1_tlast", W'({got_q[0].l, got_q[1].l, got_q[2].l}), W'(3'b001));
      chk("t1_frames", W'(frame_count), W'(1));

      // compaction of sparse valids
      got_q.delete();
      d1 = rnd_data(); d2 = rnd_data(); d3 = rnd_data();
      step(4'b0101, 1'b0, '1, d1);
      step(4'b0011, 1'b0, '1, d2);
      step(4'b1000, 1'b1, {32'h0000_FFFF, 96'h0}, d3);
      idle(4);
      chk("t2_beats", W'(got_q.size()), W'(2));
      chk("t2_beat1", got_q[0].d, {d2[511:256], d2[255:0], d1[767:512], d1[255:0]});
      chk("t2_beat2", got_q[1].d, {768'h0, d3[1023:768]});
      chk("t2_keep2", W'(got_q[1].k), W'(128'h0000_FFFF));

      // two entries written in one EOF cycle
      got_q.delete();
      d1 = rnd_data(); d2 = rnd_data();
      step(4'b0111, 1'b0, '1, d1);
      step(4'b1111, 1'b1, '1, d2);
      idle(4);
      chk("t3_beats", W'(got_q.size()), W'(2));
      chk("t3_beatA", got_q[0].d, {d2[255:0], d1[767:0]});
      chk("t3_keepB", W'(got_q[1].k), W'({32'h0, {96{1'b1}}}));
      chk("t3_tlast", W'({got_q[0].l, got_q[1].l}), W'(2'b01));

      // 20-beat frame against a stalled reader is dropped whole
      m_tready = 1'b0; got_q.delete(); pulses = 0; pulse_at = 0;
      for (int i = 0; i < 20; i++) begin
         step('1, i == 19, '1, rnd_data());
         if (gbe_tx_overflow) begin pulses++; pulse_at = i + 1; end
      end
      chk("t4_pulses", W'(pulses), W'(1));
      chk("t4_pulse_cycle", W'(pulse_at), W'(17));
      chk("t4_drops", W'(drop_count), W'(1));
      m_tready = 1'b1;
      step('1, 1'b0, '1, rnd_data());
      step('1, 1'b1, '1, rnd_data());
      idle(4);
      chk("t4_recover_beats", W'(got_q.size()), W'(2));

      // afull with twelve committed single-beat frames, then drain
      m_tready = 1'b0; got_q.delete();
      for (int i = 0; i < 12; i++) step('1, 1'b1, '1, rnd_data());
      chk("t5_afull", W'(gbe_tx_afull), W'(1));
      m_tready = 1'b1;
      idle(14);
      chk("t5_beats", W'(got_q.size()), W'(12));
      chk("t5_afull_after", W'(gbe_tx_afull), W'(0));

      // reset during beat 2 of a 4-beat frame with one frame buffered
      m_tready = 1'b0;
      step('1, 1'b1, '1, rnd_data());
      step('1, 1'b0, '1, rnd_data());
      gbe_tx_valid = '1; gbe_tx_data = rnd_data();
      #2 axis_reset_n = 1'b0;
      #1 reset_checks("midreset");
      model_clear();
      gbe_tx_valid = '0;
      @(negedge user_clk); axis_reset_n = 1'b1;
      @(posedge user_clk); #1;
      m_tready = 1'b1; got_q.delete();
      for (int i = 0; i < 4; i++) step('1, i == 3, '1, rnd_data());
      idle(6);
      chk("t6_beats", W'(got_q.size()), W'(4));
      chk("t6_frames", W'(frame_count), W'(1));

      // random traffic with stretches of backpressure
      for (int c = 0; c < 800; c++) begin
         m_tready = ((c / 50) % 3 == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
         step(NS'($urandom), $urandom_range(0, 5) == 0, rnd_be(), rnd_data());
      end
      m_tready = 1'b1;
      step('0, 1'b1, '0, '0);
      idle(24);
      chk("drained", W'(exp_q.size()), W'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
